// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with direct (handshaked) and scan modes.
// Latency: 1 cycle from accept (or scan start) to select line asserted.
// Backpressure: in_ready low outside IDLE; the source holds bin_in/in_valid until accepted.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   enable          low drives outputs to zero and returns to IDLE
//   mode            0 = direct decode of bin_in, 1 = continuous scan of all lines
//   bin_in/in_valid/in_ready  code handshake (in_ready is the only combinational output)
//   decoder_out     registered one-hot select, zero when idle
//   out_valid       decoder_out holds a line
//   code_out        registered code of the active line
//   busy            FSM not in IDLE
module decoder_scan #(
  parameter int N_IN = 4,
  parameter int HOLD = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [N_IN-1:0]      bin_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2**N_IN-1:0]   decoder_out,
  output logic                 out_valid,
  output logic [N_IN-1:0]      code_out,
  output logic                 busy
);

  localparam int NOUT = 2**N_IN;
  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [NOUT-1:0] LINE0 = {{(NOUT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NOUT-1:0] dec_q, dec_d;
  logic [N_IN-1:0] code_q, code_d;
  logic            vld_q, vld_d;
  logic [N_IN-1:0] code_nxt;

  // Wraps modulo 2**N_IN by width.
  assign code_nxt = code_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    code_d  = code_q;
    vld_d   = vld_q;

    if (!enable) begin
      // Abandon any pending slot; code_out is deliberately kept.
      state_d = ST_IDLE;
      cnt_d   = '0;
      dec_d   = '0;
      vld_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Scan wins over a simultaneous direct request; bin_in is not consumed.
          if (mode) begin
            state_d = ST_SCAN;
            cnt_d   = HOLD_M1;
            dec_d   = LINE0;
            code_d  = '0;
            vld_d   = 1'b1;
          end else if (in_valid) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_M1;
            dec_d   = LINE0 << bin_in;
            code_d  = bin_in;
            vld_d   = 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = ST_IDLE;
            dec_d   = '0;
            vld_d   = 1'b0;
          end
        end
        ST_SCAN: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else if (mode) begin
            cnt_d  = HOLD_M1;
            code_d = code_nxt;
            dec_d  = LINE0 << code_nxt;
          end else begin
            // mode is only looked at on a slot boundary, so slots never truncate.
            state_d = ST_IDLE;
            dec_d   = '0;
            vld_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          dec_d   = '0;
          vld_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dec_q   <= '0;
      code_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE) & enable & ~mode & rst_n;
  assign decoder_out = dec_q;
  assign out_valid   = vld_q;
  assign code_out    = code_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: two instances (HOLD=3 and HOLD=1) share one stimulus stream.
// Each is compared every cycle against a slot-level reference model, plus directed checks.
// Directed scenarios first, then a randomized phase.
module tb_decoder_scan;

  logic        clk = 1'b0;
  logic        rst_n, enable, mode, in_valid;
  logic [3:0]  bin_in;

  logic        rdy0, vld0, busy0, rdy1, vld1, busy1;
  logic [15:0] dec0, dec1;
  logic [3:0]  code0, code1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_scan #(.N_IN(4), .HOLD(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .bin_in(bin_in),
    .in_valid(in_valid), .in_ready(rdy0), .decoder_out(dec0), .out_valid(vld0),
    .code_out(code0), .busy(busy0)
  );

  decoder_scan #(.N_IN(4), .HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .bin_in(bin_in),
    .in_valid(in_valid), .in_ready(rdy1), .decoder_out(dec1), .out_valid(vld1),
    .code_out(code1), .busy(busy1)
  );

  // Reference model: a line is "on" for a slot of hold[i] cycles.
  int hold_cfg [2] = '{3, 1};
  bit m_on   [2];
  bit m_scan [2];
  int m_left [2];
  int m_code [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies the spec rules for one rising edge to model instance i.
  task automatic model_edge(input int i);
    if (!rst_n) begin
      m_on[i] = 0; m_scan[i] = 0; m_left[i] = 0; m_code[i] = 0;
    end else if (!enable) begin
      m_on[i] = 0; m_left[i] = 0;
    end else if (!m_on[i]) begin
      if (mode) begin
        m_on[i] = 1; m_scan[i] = 1; m_code[i] = 0; m_left[i] = hold_cfg[i];
      end else if (in_valid) begin
        m_on[i] = 1; m_scan[i] = 0; m_code[i] = int'(bin_in); m_left[i] = hold_cfg[i];
      end
    end else if (m_left[i] > 1) begin
      m_left[i] = m_left[i] - 1;
    end else if (m_scan[i] && mode) begin
      m_code[i] = (m_code[i] + 1) % 16;
      m_left[i] = hold_cfg[i];
    end else begin
      m_on[i] = 0;
    end
  endtask

  function automatic logic [31:0] exp_dec(input int i);
    return m_on[i] ? (32'd1 << m_code[i]) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_rdy(input int i);
    return {31'd0, (!m_on[i]) && enable && !mode && rst_n};
  endfunction

  task automatic check_all();
    chk("dec0",  {16'd0, dec0},  exp_dec(0));
    chk("vld0",  {31'd0, vld0},  {31'd0, m_on[0]});
    chk("busy0", {31'd0, busy0}, {31'd0, m_on[0]});
    chk("code0", {28'd0, code0}, m_code[0]);
    chk("rdy0",  {31'd0, rdy0},  exp_rdy(0));
    chk("onehot0", $countones(dec0) <= 1, 32'd1);
    chk("dec1",  {16'd0, dec1},  exp_dec(1));
    chk("vld1",  {31'd0, vld1},  {31'd0, m_on[1]});
    chk("busy1", {31'd0, busy1}, {31'd0, m_on[1]});
    chk("code1", {28'd0, code1}, m_code[1]);
    chk("rdy1",  {31'd0, rdy1},  exp_rdy(1));
  endtask

  // One clock: update model at the edge, sample DUT 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all();
  endtask

  // Let combinational in_ready settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; in_valid = 1'b0; bin_in = 4'h0;
    for (int i = 0; i < 2; i++) begin
      m_on[i] = 0; m_scan[i] = 0; m_left[i] = 0; m_code[i] = 0;
    end
    step();
    step();
    chk("reset_dec0", {16'd0, dec0}, 32'h0);
    chk("reset_rdy0_in_reset", {31'd0, rdy0}, 32'd0);

    // Direct decode of code 5 with HOLD=3.
    rst_n = 1'b1; enable = 1'b1; bin_in = 4'h5; in_valid = 1'b1;
    settle();
    chk("t1_ready", {31'd0, rdy0}, 32'd1);
    step();
    in_valid = 1'b0; bin_in = 4'hA;
    for (int k = 0; k < 3; k++) begin
      chk("t1_line", {16'd0, dec0}, 32'h0020);
      chk("t1_code", {28'd0, code0}, 32'd5);
      if (k < 2) step();
    end
    step();
    chk("t1_off", {16'd0, dec0}, 32'h0);
    chk("t1_ready_after", {31'd0, rdy0}, 32'd1);

    // Full direct sweep; source holds each code until accepted.
    for (int c = 0; c < 16; c++) begin
      bin_in = 4'(c); in_valid = 1'b1;
      settle();
      guard = 0;
      while (!rdy0 && guard < 20) begin
        step();
        guard++;
      end
      chk("sweep_timeout", guard < 20, 32'd1);
      step();
      chk("sweep_line", {16'd0, dec0}, 32'd1 << c);
      in_valid = 1'b0;
    end
    for (int k = 0; k < 4; k++) step();

    // Scan wrap; dut1 (HOLD=1) advances every cycle.
    mode = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step();
      chk("scan_code1", {28'd0, code1}, k % 16);
      chk("scan_line1", {16'd0, dec1}, 32'd1 << (k % 16));
    end
    mode = 1'b0;
    step();
    chk("scan_stop1", {16'd0, dec1}, 32'h0);
    for (int k = 0; k < 4; k++) step();
    chk("scan_stop0", {31'd0, vld0}, 32'd0);

    // Enable drop on the second hold cycle.
    bin_in = 4'h9; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("en_line9", {16'd0, dec0}, 32'h0200);
    step();
    enable = 1'b0;
    step();
    chk("en_drop_dec", {16'd0, dec0}, 32'h0);
    chk("en_drop_busy", {31'd0, busy0}, 32'd0);
    chk("en_drop_code_kept", {28'd0, code0}, 32'd9);
    enable = 1'b1; bin_in = 4'h2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("en_line2", {16'd0, dec0}, 32'h0004);
    for (int k = 0; k < 4; k++) step();

    // Reset mid-scan at code 7.
    mode = 1'b1;
    guard = 0;
    do begin
      step();
      guard++;
    end while (code0 != 4'd7 && guard < 60);
    chk("rst_reach7", {28'd0, code0}, 32'd7);
    rst_n = 1'b0;
    step();
    chk("rst_dec", {16'd0, dec0}, 32'h0);
    chk("rst_code", {28'd0, code0}, 32'h0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_restart", {16'd0, dec0}, 32'h0001);
    mode = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // Simultaneous in_valid and mode in IDLE: scan wins.
    in_valid = 1'b1; bin_in = 4'h3; mode = 1'b1;
    settle();
    chk("sim_ready", {31'd0, rdy0}, 32'd0);
    step();
    chk("sim_scan_code", {28'd0, code0}, 32'd0);
    chk("sim_scan_line", {16'd0, dec0}, 32'h0001);
    mode = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // Randomized phase.
    for (int n = 0; n < 600; n++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      enable   = ($urandom_range(0, 9) != 0);
      mode     = ($urandom_range(0, 3) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      bin_in   = 4'($urandom_range(0, 15));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
